// File: rtl/pm_loader.sv
// Program-memory loader: turns a length/payload/checksum nibble stream into
// sequential 8-bit instruction writes, holding the MPU core in reset meanwhile.
module pm_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int NIB_W  = 4
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              load_req,
    input  logic              nib_valid,
    input  logic [NIB_W-1:0]  nib_data,
    output logic              nib_ready,
    output logic              pm_wr_en,
    output logic [ADDR_W-1:0] pm_wr_addr,
    output logic [DATA_W-1:0] pm_wr_data,
    output logic              mpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_INS_HI,
        S_INS_LO,
        S_CHK_HI,
        S_CHK_LO,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    state_t              state_n;

    logic [NIB_W-1:0]    hi_q;
    logic [DATA_W-1:0]   len_q;
    logic [ADDR_W-1:0]   count;
    logic [DATA_W-1:0]   sum;

    logic                xfer;
    logic                start;
    logic                wr;
    logic                done;
    logic                err;
    logic                lat_hi;
    logic                lat_len;
    logic [DATA_W-1:0]   byte_w;
    logic [ADDR_W:0]     len_ext;
    logic [ADDR_W:0]     cnt_nxt;
    logic                last;

    assign byte_w  = {hi_q, nib_data};
    assign xfer    = nib_valid & nib_ready;
    assign cnt_nxt = {1'b0, count} + (ADDR_W+1)'(1);
    assign last    = cnt_nxt >= len_ext;

    // A zero length field encodes a completely filled program memory.
    always_comb begin
        len_ext = (ADDR_W+1)'(len_q);
        if (len_q == '0) begin
            len_ext = {1'b1, {ADDR_W{1'b0}}};
        end
    end

    always_comb begin
        state_n   = state;
        nib_ready = 1'b0;
        start     = 1'b0;
        wr        = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        lat_hi    = 1'b0;
        lat_len   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_req) begin
                    start   = 1'b1;
                    state_n = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                nib_ready = 1'b1;
                if (xfer) begin
                    lat_hi  = 1'b1;
                    state_n = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                nib_ready = 1'b1;
                if (xfer) begin
                    lat_len = 1'b1;
                    state_n = S_INS_HI;
                end
            end
            S_INS_HI: begin
                nib_ready = 1'b1;
                if (xfer) begin
                    lat_hi  = 1'b1;
                    state_n = S_INS_LO;
                end
            end
            S_INS_LO: begin
                nib_ready = 1'b1;
                if (xfer) begin
                    wr      = 1'b1;
                    state_n = last ? S_CHK_HI : S_INS_HI;
                end
            end
            S_CHK_HI: begin
                nib_ready = 1'b1;
                if (xfer) begin
                    lat_hi  = 1'b1;
                    state_n = S_CHK_LO;
                end
            end
            S_CHK_LO: begin
                nib_ready = 1'b1;
                if (xfer) begin
                    if (byte_w == sum) begin
                        done    = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        err     = 1'b1;
                        state_n = S_ERR;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= S_IDLE;
            hi_q       <= '0;
            len_q      <= '0;
            count      <= '0;
            sum        <= '0;
            pm_wr_en   <= 1'b0;
            pm_wr_addr <= '0;
            pm_wr_data <= '0;
            mpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state     <= state_n;
            pm_wr_en  <= wr;
            load_done <= done;
            if (start) begin
                mpu_hold <= 1'b1;
                load_err <= 1'b0;
                count    <= '0;
                sum      <= '0;
            end
            if (lat_hi) begin
                hi_q <= nib_data;
            end
            if (lat_len) begin
                len_q <= byte_w;
            end
            // Write is registered; count wraps to 0 after a full-memory image.
            if (wr) begin
                pm_wr_addr <= count;
                pm_wr_data <= byte_w;
                sum        <= sum + byte_w;
                count      <= count + ADDR_W'(1);
            end
            if (done) begin
                mpu_hold <= 1'b0;
            end
            if (err) begin
                load_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// Directed bench for pm_loader: reset, good/bad/max-length loads,
// valid gaps and mid-load abort.
module tb_pm_loader;

    logic       clk;
    logic       sync_reset;
    logic       load_req;
    logic       nib_valid;
    logic [3:0] nib_data;
    logic       nib_ready;
    logic       pm_wr_en;
    logic [7:0] pm_wr_addr;
    logic [7:0] pm_wr_data;
    logic       mpu_hold;
    logic       load_done;
    logic       load_err;

    int vectors;
    int miscompares;

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         done_cnt;
    logic       hold_at_done;

    pm_loader dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .load_req   (load_req),
        .nib_valid  (nib_valid),
        .nib_data   (nib_data),
        .nib_ready  (nib_ready),
        .pm_wr_en   (pm_wr_en),
        .pm_wr_addr (pm_wr_addr),
        .pm_wr_data (pm_wr_data),
        .mpu_hold   (mpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pm_wr_en) begin
            wa.push_back(pm_wr_addr);
            wd.push_back(pm_wr_data);
        end
        if (load_done) begin
            done_cnt++;
            hold_at_done = mpu_hold;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] n, input int gap);
        nib_valid = 1'b0;
        idle(gap);
        nib_valid = 1'b1;
        nib_data  = n;
        @(posedge clk);
        #1;
        nib_valid = 1'b0;
    endtask

    task automatic send_img(input logic [3:0] img[$], input bit gaps);
        foreach (img[i]) begin
            send(img[i], gaps ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic start();
        load_req = 1'b1;
        idle(1);
        load_req = 1'b0;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt     = 0;
        hold_at_done = 1'bx;
    endtask

    task automatic check_good(input string t);
        chk({t, "_nwr"}, wa.size(), 3);
        if (wa.size() == 3) begin
            chk({t, "_a0"}, {wa[0], wd[0]}, 16'h0012);
            chk({t, "_a1"}, {wa[1], wd[1]}, 16'h0134);
            chk({t, "_a2"}, {wa[2], wd[2]}, 16'h0256);
        end
        chk({t, "_done"}, done_cnt, 1);
        chk({t, "_hold_at_done"}, hold_at_done, 0);
        chk({t, "_hold"}, mpu_hold, 0);
        chk({t, "_err"}, load_err, 0);
    endtask

    logic [3:0] good[$];
    logic [3:0] bad[$];
    logic [3:0] big[$];
    logic [3:0] tail[$];

    initial begin
        vectors     = 0;
        miscompares = 0;
        sync_reset  = 1'b1;
        load_req    = 1'b0;
        nib_valid   = 1'b1;
        nib_data    = 4'h3;
        clear_log();

        good = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4,
                 4'h5, 4'h6, 4'h9, 4'hC};
        bad  = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4,
                 4'h5, 4'h6, 4'h0, 4'h0};
        tail = '{4'h5, 4'h6, 4'h9, 4'hC};
        big  = '{4'h0, 4'h0};
        for (int i = 0; i < 256; i++) begin
            big.push_back(4'h0);
            big.push_back(4'h1);
        end
        big.push_back(4'h0);
        big.push_back(4'h0);

        // 1: reset, nibbles offered while idle are refused
        idle(2);
        chk("rst_outs", {nib_ready, pm_wr_en, mpu_hold, load_done,
                         load_err}, 0);
        chk("rst_addr_data", {pm_wr_addr, pm_wr_data}, 0);
        sync_reset = 1'b0;
        idle(2);
        chk("idle_ready", nib_ready, 0);
        chk("idle_hold", mpu_hold, 0);
        nib_valid = 1'b0;
        idle(1);
        chk("idle_nwr", wa.size(), 0);

        // 2: good load
        clear_log();
        start();
        chk("t2_hold_start", mpu_hold, 1);
        chk("t2_ready", nib_ready, 1);
        send_img(good, 1'b0);
        idle(3);
        check_good("t2");

        // 3: bad checksum, then reload
        clear_log();
        start();
        send_img(bad, 1'b0);
        idle(3);
        chk("t3_err", load_err, 1);
        chk("t3_hold", mpu_hold, 1);
        chk("t3_done", done_cnt, 0);
        chk("t3_nwr", wa.size(), 3);
        chk("t3_ready", nib_ready, 0);
        clear_log();
        start();
        chk("t3_err_clr", load_err, 0);
        send_img(good, 1'b0);
        idle(3);
        check_good("t3r");

        // 4: L=0 means 256 instructions
        clear_log();
        start();
        send_img(big, 1'b0);
        idle(5);
        chk("t4_nwr", wa.size(), 256);
        if (wa.size() == 256) begin
            chk("t4_first", {wa[0], wd[0]}, 16'h0001);
            chk("t4_last", {wa[255], wd[255]}, 16'hFF01);
            chk("t4_mid", {wa[128], wd[128]}, 16'h8001);
        end
        chk("t4_done", done_cnt, 1);
        chk("t4_err", load_err, 0);
        chk("t4_hold", mpu_hold, 0);

        // 5: random valid gaps
        clear_log();
        start();
        send_img(good, 1'b1);
        idle(3);
        check_good("t5");

        // 6: abort after two instructions
        clear_log();
        start();
        send(4'h0, 0);
        send(4'h3, 0);
        send(4'h1, 0);
        send(4'h2, 0);
        send(4'h3, 0);
        send(4'h4, 0);
        chk("t6_wr2", {pm_wr_en, pm_wr_addr, pm_wr_data}, 17'h10134);
        sync_reset = 1'b1;
        idle(1);
        chk("t6_outs", {nib_ready, pm_wr_en, mpu_hold, load_done,
                        load_err}, 0);
        chk("t6_addr_data", {pm_wr_addr, pm_wr_data}, 0);
        sync_reset = 1'b0;
        send_img(tail, 1'b0);
        idle(3);
        chk("t6_nwr", wa.size(), 2);
        chk("t6_done", done_cnt, 0);
        chk("t6_hold", mpu_hold, 0);
        chk("t6_ready", nib_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
